// File: rtl/lr_shift_pkg.sv
// Shared definitions for the left/right shift datapath (receiver and future transmitter).
//   state_e    : receiver word-collection state
//   DIR_LEFT   : shift left, MSB-first on the serial side
//   DIR_RIGHT  : shift right, LSB-first on the serial side
//   cnt_width(): bit-counter width for a given word width
package lr_shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // Counter must hold 0..width-1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/lr_sipo_rx_if.sv
// Serial-in / parallel-out bus for lr_sipo_rx.
//   master : bit source + parallel consumer side (drives lr_bar, sin, sin_valid, flush, y_ready)
//   slave  : receiver side (drives y, y_valid, overrun)
interface lr_sipo_rx_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             lr_bar;
    logic             sin;
    logic             sin_valid;
    logic             flush;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic             overrun;

    modport master (
        output lr_bar, sin, sin_valid, flush, y_ready,
        input  y, y_valid, overrun
    );

    modport slave (
        input  lr_bar, sin, sin_valid, flush, y_ready,
        output y, y_valid, overrun
    );

endinterface

// File: rtl/lr_shift_core.sv
// WIDTH-bit shift register with enable, synchronous clear, direction and serial input.
//   clk, rst : clock, asynchronous active-high reset
//   en       : shift on this edge
//   clr      : clear register (wins over en)
//   dir      : DIR_LEFT shifts sin in at bit 0, DIR_RIGHT shifts sin in at the MSB
//   sin      : serial data bit
//   shift_c  : combinational post-shift value (the value the register takes when en=1)
module lr_shift_core
    import lr_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] shift_c
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    // Shifted value for the current direction
    always_comb begin
        shift_c = sreg_q;
        case (dir)
            DIR_LEFT:  shift_c = {sreg_q[WIDTH-2:0], sin};
            DIR_RIGHT: shift_c = {sin, sreg_q[WIDTH-1:1]};
            default:   shift_c = sreg_q;
        endcase
    end

    // Next register value
    always_comb begin
        sreg_d = sreg_q;
        if (clr) begin
            sreg_d = '0;
        end else if (en) begin
            sreg_d = shift_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

endmodule

// File: rtl/lr_sipo_rx.sv
// Serial-in, parallel-out receiver: collects WIDTH bits MSB-first or LSB-first into a word
// and holds it behind a valid/ready handshake while the next word is collected.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lr_sipo_rx_if slave (lr_bar, sin, sin_valid, flush in; y, y_valid, overrun out;
//              y_ready in)
module lr_sipo_rx
    import lr_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    lr_sipo_rx_if.slave bus
);

    localparam int unsigned       CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dir_q,   dir_d;
    logic [WIDTH-1:0] y_q,     y_d;
    logic             y_valid_q, y_valid_d;
    logic             overrun_q, overrun_d;

    logic             accept_c;
    logic             first_c;
    logic             dir_c;
    logic             last_c;
    logic             consume_c;
    logic [WIDTH-1:0] word_c;

    // Bit acceptance, direction selection and handshake qualifiers
    always_comb begin
        accept_c  = bus.sin_valid & ~bus.flush;
        first_c   = (state_q == IDLE);
        // The first bit of a word uses lr_bar directly; later bits use the latched direction.
        dir_c     = first_c ? bus.lr_bar : dir_q;
        last_c    = accept_c & (cnt_q == LAST);
        consume_c = y_valid_q & bus.y_ready;
    end

    lr_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .en      (accept_c),
        .clr     (bus.flush),
        .dir     (dir_c),
        .sin     (bus.sin),
        .shift_c (word_c)
    );

    // Word-collection FSM, bit counter and direction latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept_c) begin
            if (first_c) begin
                dir_d = bus.lr_bar;
            end
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = SHIFT;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output holding register and sticky overrun
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        overrun_d = overrun_q;
        if (consume_c) begin
            y_valid_d = 1'b0;
        end
        if (last_c) begin
            // A completed word lands if the slot is empty or being emptied on this edge.
            if (!y_valid_q || consume_c) begin
                y_d       = word_c;
                y_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (bus.flush) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= DIR_LEFT;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.overrun = overrun_q;

endmodule
